seq_svm_lanes: RTL and testbench
================================

Name: seq_svm_lanes

Overview:
Sequential linear-SVM classifier and successor to the single-MAC binary SVM engine. It processes LANES features per cycle, so the number of lanes trades multiplier count against latency. Unlike the single-MAC engine, it adds a start/done handshake, an input capture register and a readable signed score output. It sits behind the feature front-end. Several instances, each with its own weight and bias set, feed the one-vs-rest or voting stage.

Parameters:
N_FEATURES, 16, number of features.
IN_W, 8, unsigned feature width.
W_W, 8, signed weight width.
B_W, 8, signed bias width.
BIAS_SHIFT, 4, left shift applied to bias before it is added.
LANES, 2, multipliers per cycle, 1..N_FEATURES.
ACC_W, 20, signed accumulator and score width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a classification; sampled only when idle
inputs  in  IN_W*N_FEATURES  feature vector, feature i at [i*IN_W +: IN_W]
weights  in  W_W*N_FEATURES  signed weights, same packing; held static during operation
bias  in  B_W  signed bias; held static during operation
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when score/class_o update
score  out  ACC_W  signed decision value
class_o  out  1  sign of score (1 = negative)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All state clears on reset: busy=0, done=0, score=0, class_o=0, FSM=IDLE, beat counter=0, input capture register=0.
- BEATS = ceil(N_FEATURES/LANES). Beat counter width = $clog2(BEATS+1).
- FSM states are IDLE, ACC and BIAS.
- IDLE:
  - When start=1 on an edge: capture inputs into an internal register, clear the accumulator, set beat=0, go to ACC, set busy=1.
  - When start=0: done is 0.
- ACC:
  - Each cycle: acc += sum over lanes l of $signed(w[j]) * $signed({1'b0,x[j]}), with j = beat*LANES + l.
  - Lanes with j >= N_FEATURES contribute 0. No out-of-range index is ever formed.
  - The lane sum is formed at full precision (W_W+IN_W+1+$clog2(LANES) bits) and sign-extended or truncated to ACC_W on the add.
  - After beat BEATS-1, go to BIAS.
- BIAS (one cycle):
  - score <= acc + (sign-extended bias << BIAS_SHIFT).
  - class_o <= sign bit of that value.
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: start sampled at edge 0, then done=1 and the new score are valid after edge BEATS+1. Throughput is one result per BEATS+2 cycles.
- Back-to-back: start asserted in the cycle done is high is accepted, because the FSM is already IDLE.
- start while busy: ignored; no queueing.
- The inputs port may change freely after start is accepted, because it is captured. weights and bias are not captured; they must stay static while busy.
- score and class_o hold their values between completions.
- Arithmetic is two's-complement and wraps modulo 2^ACC_W at every add, unless saturation is enabled.
- Reset asserted mid-operation aborts the operation: outputs return to their reset values and no done pulse is produced.
- LANES=1 with N_FEATURES=16 gives 16 beats, which is the single-MAC-equivalent mode.

Optional Feature:
- Macro: SVM_ACC_SAT_EN.
- Defined: every accumulator add, including the bias add, saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Saturation is sticky per add only; later adds may move the value away from the rail.
- Undefined: wrap-around arithmetic, with no saturation logic synthesized.

Test Plan:
- Basic result. Setup: N=4, LANES=2, IN_W=W_W=B_W=4, BIAS_SHIFT=4, ACC_W=12; weights all +1, inputs {1,2,3,4}, bias=-1; pulse start. Required: done pulses exactly 3 cycles after the start edge, score=-6, class_o=1, busy high for 3 cycles.
- Same setup with bias=0. Required: score=10, class_o=0; done is a single cycle and score holds afterwards.
- Padded lanes. Setup: LANES=3, N=4, weights {2,-1,3,1}, inputs {5,6,7,8}, bias=0. Required: BEATS=2, done after 3 cycles, score=33.
- start re-asserted during busy, and inputs changed mid-run. Required: only one done, and the result matches the captured inputs.
- A second start on the done cycle. Required: accepted; the next done arrives BEATS+2 cycles after the first.
- Reset asserted at beat 1. Required: busy, done, score and class_o go to 0 immediately, and no done pulse follows.
- Overflow. Setup: ACC_W=8, N=4, LANES=2, weights all -8, inputs all 15, bias=0. Required: score=32 and class_o=0 without SVM_ACC_SAT_EN; score=-128 and class_o=1 with it.

Source files
------------

// File: rtl/seq_svm_lanes.sv
// Sequential linear-SVM classifier processing LANES features per beat, with start/done handshake.
// Define SVM_ACC_SAT_EN to saturate every accumulator add (including the bias add) instead of wrapping.
module seq_svm_lanes #(
    parameter int N_FEATURES = 16,
    parameter int IN_W       = 8,
    parameter int W_W        = 8,
    parameter int B_W        = 8,
    parameter int BIAS_SHIFT = 4,
    parameter int LANES      = 2,
    parameter int ACC_W      = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [IN_W*N_FEATURES-1:0] inputs,
    input  logic [W_W*N_FEATURES-1:0]  weights,
    input  logic [B_W-1:0]             bias,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           score,
    output logic                       class_o
);

    // state | meaning
    // IDLE  | waiting for start; inputs captured on acceptance
    // ACC   | one beat per cycle, LANES products summed into acc
    // BIAS  | add shifted bias, publish score/class_o, pulse done
    typedef enum logic [1:0] {IDLE, ACC, BIAS} state_t;

    localparam int BEATS  = (N_FEATURES + LANES - 1) / LANES;
    localparam int CW     = $clog2(BEATS + 1);
    localparam int PROD_W = W_W + IN_W + 1;
    localparam int LSUM_W = PROD_W + $clog2(LANES);
    localparam int BT_W   = B_W + BIAS_SHIFT;
    localparam int WIDE_W = ACC_W + LSUM_W + BT_W + 1;

`ifdef SVM_ACC_SAT_EN
    localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_t                     state_q, state_d;
    logic [CW-1:0]              beat_q, beat_d;
    logic [IN_W*N_FEATURES-1:0] x_q, x_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]           score_d;
    logic                       class_d, done_d, busy_d;

    logic [W_W-1:0]             w_tab [LANES][BEATS];
    logic [IN_W-1:0]            x_tab [LANES][BEATS];
    logic signed [PROD_W-1:0]   prod [LANES];
    logic signed [LSUM_W-1:0]   lane_sum;
    logic signed [WIDE_W-1:0]   bias_term;
    logic signed [ACC_W-1:0]    acc_next, bias_sum;

    // The operand tables are padded with zeros so a lane past N_FEATURES
    // multiplies 0 and no out-of-range feature slice is ever formed.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar b = 0; b < BEATS; b++) begin : g_beat
            localparam int J = b * LANES + l;
            if (J < N_FEATURES) begin : g_real
                assign w_tab[l][b] = weights[J*W_W +: W_W];
                assign x_tab[l][b] = x_q[J*IN_W +: IN_W];
            end else begin : g_pad
                assign w_tab[l][b] = '0;
                assign x_tab[l][b] = '0;
            end
        end

        logic [W_W-1:0]  w_sel;
        logic [IN_W-1:0] x_sel;
        always_comb begin
            w_sel = '0;
            x_sel = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (beat_q == CW'(b)) begin
                    w_sel = w_tab[l][b];
                    x_sel = x_tab[l][b];
                end
            end
            prod[l] = PROD_W'($signed(w_sel)) * PROD_W'($signed({1'b0, x_sel}));
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + LSUM_W'(prod[l]);
        end
    end

    // Adds are done wide, then wrapped (truncated) or clamped to ACC_W.
    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0]  a,
                                                        input logic signed [WIDE_W-1:0] b);
        logic signed [WIDE_W-1:0] s;
        s = WIDE_W'(a) + b;
`ifdef SVM_ACC_SAT_EN
        if (s > SAT_MAX) s = SAT_MAX;
        else if (s < SAT_MIN) s = SAT_MIN;
`endif
        return $signed(s[ACC_W-1:0]);
    endfunction

    assign bias_term = WIDE_W'($signed(bias)) <<< BIAS_SHIFT;
    assign acc_next  = acc_add(acc_q, WIDE_W'(lane_sum));
    assign bias_sum  = acc_add(acc_q, bias_term);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        x_d     = x_q;
        acc_d   = acc_q;
        score_d = score;
        class_d = class_o;
        done_d  = 1'b0;
        busy_d  = busy;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = inputs;
                    acc_d   = '0;
                    beat_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d  = acc_next;
                beat_d = beat_q + CW'(1);
                if (beat_q == CW'(BEATS - 1)) state_d = BIAS;
            end
            BIAS: begin
                score_d = bias_sum;
                class_d = bias_sum[ACC_W-1];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            score   <= '0;
            class_o <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            score   <= score_d;
            class_o <= class_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_seq_svm_lanes.sv
// Directed bench for seq_svm_lanes: three small instances (2 lanes, padded 3 lanes, 8-bit overflow).
module tb_seq_svm_lanes;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [15:0] in_a = '0, in_b = '0, in_c = '0;
    logic [15:0] w_a = '0, w_b = '0, w_c = '0;
    logic [3:0]  b_a = '0, b_b = '0, b_c = '0;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [11:0] score_a, score_b;
    logic [7:0]  score_c;
    logic        cls_a, cls_b, cls_c;

    seq_svm_lanes #(.N_FEATURES(4), .IN_W(4), .W_W(4), .B_W(4), .BIAS_SHIFT(4), .LANES(2), .ACC_W(12)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .inputs(in_a), .weights(w_a), .bias(b_a),
        .busy(busy_a), .done(done_a), .score(score_a), .class_o(cls_a));

    seq_svm_lanes #(.N_FEATURES(4), .IN_W(4), .W_W(4), .B_W(4), .BIAS_SHIFT(4), .LANES(3), .ACC_W(12)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .inputs(in_b), .weights(w_b), .bias(b_b),
        .busy(busy_b), .done(done_b), .score(score_b), .class_o(cls_b));

    seq_svm_lanes #(.N_FEATURES(4), .IN_W(4), .W_W(4), .B_W(4), .BIAS_SHIFT(4), .LANES(2), .ACC_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .inputs(in_c), .weights(w_c), .bias(b_c),
        .busy(busy_c), .done(done_c), .score(score_c), .class_o(cls_c));

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
        checks++; if (score_a !== 12'h000) begin errors++; $display("FAIL reset_score got %h want 000", score_a); end
        checks++; if (cls_a !== 1'b0) begin errors++; $display("FAIL reset_class got %b want 0", cls_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // weights all +1, inputs {1,2,3,4}, bias -1: 10 - 16 = -6
    task automatic test_basic();
        int nd = 0, fd = -1, nb = 0;
        logic [11:0] sc = '0;
        logic cl = 1'b0;
        w_a = 16'h1111; in_a = 16'h4321; b_a = 4'hF;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        if (busy_a) nb++;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (busy_a) nb++;
            if (done_a) begin nd++; if (fd < 0) begin fd = k; sc = score_a; cl = cls_a; end end
        end
        checks++; if (fd !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", fd); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", nd); end
        checks++; if (nb !== 3) begin errors++; $display("FAIL basic_busy_cycles got %0d want 3", nb); end
        checks++; if (sc !== 12'hFFA) begin errors++; $display("FAIL basic_score got %h want ffa", sc); end
        checks++; if (cl !== 1'b1) begin errors++; $display("FAIL basic_class got %b want 1", cl); end
    endtask

    task automatic test_bias_zero();
        int nd = 0, fd = -1;
        logic [11:0] sc = '0;
        logic cl = 1'b1;
        w_a = 16'h1111; in_a = 16'h4321; b_a = 4'h0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (done_a) begin nd++; if (fd < 0) begin fd = k; sc = score_a; cl = cls_a; end end
        end
        checks++; if (sc !== 12'h00A) begin errors++; $display("FAIL bias0_score got %h want 00a", sc); end
        checks++; if (cl !== 1'b0) begin errors++; $display("FAIL bias0_class got %b want 0", cl); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL bias0_done_count got %0d want 1", nd); end
        checks++; if (score_a !== 12'h00A) begin errors++; $display("FAIL bias0_score_hold got %h want 00a", score_a); end
    endtask

    // LANES=3, N=4: weights {2,-1,3,1} . inputs {5,6,7,8} = 33
    task automatic test_padded();
        int nd = 0, fd = -1;
        logic [11:0] sc = '0;
        w_b = 16'h13F2; in_b = 16'h8765; b_b = 4'h0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (done_b) begin nd++; if (fd < 0) begin fd = k; sc = score_b; end end
        end
        checks++; if (fd !== 3) begin errors++; $display("FAIL padded_latency got %0d want 3", fd); end
        checks++; if (sc !== 12'h021) begin errors++; $display("FAIL padded_score got %h want 021", sc); end
        checks++; if (cls_b !== 1'b0) begin errors++; $display("FAIL padded_class got %b want 0", cls_b); end
    endtask

    // start held and inputs changed while busy: result must use captured {1,2,3,4}
    task automatic test_busy_restart();
        int nd = 0;
        logic [11:0] sc = '0;
        w_a = 16'h1111; in_a = 16'h4321; b_a = 4'h0;
        start_a = 1'b1;
        @(posedge clk); #1;
        in_a = 16'hFFFF;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 2) start_a = 1'b0;
            if (done_a) begin nd++; sc = score_a; end
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", nd); end
        checks++; if (sc !== 12'h00A) begin errors++; $display("FAIL restart_score got %h want 00a", sc); end
    endtask

    task automatic test_back_to_back();
        int nd = 0, fd = -1, sd = -1;
        logic [11:0] sc2 = '0;
        w_a = 16'h1111; in_a = 16'h4321; b_a = 4'h0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            if (done_a) begin
                nd++;
                if (fd < 0) begin
                    fd = k;
                    in_a = 16'h1111;
                    start_a = 1'b1;
                end else if (sd < 0) begin
                    sd = k;
                    sc2 = score_a;
                end
            end
        end
        checks++; if (fd !== 3) begin errors++; $display("FAIL b2b_first got %0d want 3", fd); end
        checks++; if (sd !== 7) begin errors++; $display("FAIL b2b_second got %0d want 7", sd); end
        checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", nd); end
        checks++; if (sc2 !== 12'h004) begin errors++; $display("FAIL b2b_score got %h want 004", sc2); end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        w_a = 16'h1111; in_a = 16'h4321; b_a = 4'hF;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done_a); end
        checks++; if (score_a !== 12'h000) begin errors++; $display("FAIL midrst_score got %h want 000", score_a); end
        checks++; if (cls_a !== 1'b0) begin errors++; $display("FAIL midrst_class got %b want 0", cls_a); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done_a) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", nd); end
    endtask

    // weights all -8, inputs all 15: -480 wraps to 32, saturates to -128
    task automatic test_overflow();
        int fd = -1;
        logic [7:0] sc = '0;
        logic cl = 1'b0;
        logic [7:0] exp_sc;
        logic exp_cl;
`ifdef SVM_ACC_SAT_EN
        exp_sc = 8'h80; exp_cl = 1'b1;
`else
        exp_sc = 8'h20; exp_cl = 1'b0;
`endif
        w_c = 16'h8888; in_c = 16'hFFFF; b_c = 4'h0;
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (done_c && fd < 0) begin fd = k; sc = score_c; cl = cls_c; end
        end
        checks++; if (fd !== 3) begin errors++; $display("FAIL ovf_latency got %0d want 3", fd); end
        checks++; if (sc !== exp_sc) begin errors++; $display("FAIL ovf_score got %h want %h", sc, exp_sc); end
        checks++; if (cl !== exp_cl) begin errors++; $display("FAIL ovf_class got %b want %b", cl, exp_cl); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias_zero();
        test_padded();
        test_busy_restart();
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
